// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Inverse of the single-cycle control decoder. A 10-bit control vector
//   {Jump,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0]}
//   is mapped back to its opcode and, together with the operand fields, packed
//   into a 32-bit MIPS instruction word. Words leave through a one-entry
//   valid/ready output register, each tagged with a sequential word address.
//   Control vectors outside the decode table are consumed, flagged with a
//   one-cycle error pulse and produce no word.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready = ~out_valid | out_ready)
//   in_ctrl               control vector to encode
//   in_rs, in_rt, in_rd   register fields (rd only used by R-format)
//   in_shamt, in_funct    R-format shift amount and function code
//   in_imm                I-format immediate / offset
//   in_target             J-format jump target
//   out_valid/out_ready   output handshake
//   out_instr, out_addr   encoded word and its word address
//   err_valid, err_ctrl   rejected-vector pulse and last rejected vector
//   count                 legal words accepted since reset, saturating at 2^ADDR_W
//   wrap                  pulse when the word loaded used the last address

module mips_instr_encoder #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_ctrl,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [9:0]        err_ctrl,
    output logic [ADDR_W:0]   count,
    output logic              wrap
);

    localparam logic [9:0] CTRL_R    = 10'b0100100010;
    localparam logic [9:0] CTRL_LW   = 10'b0011110000;
    localparam logic [9:0] CTRL_SW   = 10'b0010001000;
    localparam logic [9:0] CTRL_BEQ  = 10'b0000000101;
    localparam logic [9:0] CTRL_ADDI = 10'b0010100000;
    localparam logic [9:0] CTRL_J    = 10'b1000000000;

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [31:0]       instr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_ctr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              err_valid_reg;
    logic [9:0]        err_ctrl_reg;
    logic              wrap_reg;

    logic        enc_legal;
    logic [31:0] enc_word;
    logic        accept;
    logic        legal_accept;
    logic        illegal_accept;

    // Control vector -> opcode and field packing. Fields a format does not
    // use are simply left out of the word.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (in_ctrl)
            CTRL_R:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            CTRL_LW:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
            CTRL_SW:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
            CTRL_BEQ:  enc_word = {6'b000100, in_rs, in_rt, in_imm};
            CTRL_ADDI: enc_word = {6'b001000, in_rs, in_rt, in_imm};
            CTRL_J:    enc_word = {6'b000010, in_target};
            default:   enc_legal = 1'b0;
        endcase
    end

    assign out_valid      = (state_reg == FULL);
    assign in_ready       = ~out_valid | out_ready;
    assign accept         = in_valid & in_ready;
    assign legal_accept   = accept & enc_legal;
    assign illegal_accept = accept & ~enc_legal;

    // Output-stage state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // A legal accept always (re)fills the register; otherwise a taken word
    // empties it. An illegal accept leaves the stage alone.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (legal_accept) state_next = FULL;
            end
            FULL: begin
                if (legal_accept)   state_next = FULL;
                else if (out_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Word, address, counters and error/wrap pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg     <= '0;
            addr_reg      <= BASE_ADDR;
            addr_ctr_reg  <= BASE_ADDR;
            count_reg     <= '0;
            err_valid_reg <= 1'b0;
            err_ctrl_reg  <= '0;
            wrap_reg      <= 1'b0;
        end else begin
            err_valid_reg <= illegal_accept;
            // The pulse coincides with the load of the word that used the
            // last address, so the next word starts again at zero.
            wrap_reg      <= legal_accept & (&addr_ctr_reg);
            if (illegal_accept) begin
                err_ctrl_reg <= in_ctrl;
            end
            if (legal_accept) begin
                instr_reg    <= enc_word;
                addr_reg     <= addr_ctr_reg;
                addr_ctr_reg <= addr_ctr_reg + ADDR_W'(1);
                if (count_reg != COUNT_MAX) begin
                    count_reg <= count_reg + (ADDR_W+1)'(1);
                end
            end
        end
    end

    assign out_instr = instr_reg;
    assign out_addr  = addr_reg;
    assign err_valid = err_valid_reg;
    assign err_ctrl  = err_ctrl_reg;
    assign count     = count_reg;
    assign wrap      = wrap_reg;

endmodule
